// File: rtl/fp_ci_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fp_ci_pkg
//  Description : Shared state encoding and default sizing for the
//                floating-point custom-instruction initiator.
//  Revision    : 1.0 - initial release
// ============================================================================
package fp_ci_pkg;

    localparam int DEFAULT_DATA_WIDTH     = 32;
    localparam int DEFAULT_COUNTER_WIDTH  = 10;
    localparam int DEFAULT_TIMEOUT_CYCLES = 64;

    localparam int STATE_W = 3;

    localparam logic [STATE_W-1:0] S_FLUSH = 3'd0;
    localparam logic [STATE_W-1:0] S_IDLE  = 3'd1;
    localparam logic [STATE_W-1:0] S_ISSUE = 3'd2;
    localparam logic [STATE_W-1:0] S_WAIT  = 3'd3;
    localparam logic [STATE_W-1:0] S_RESP  = 3'd4;

endpackage
`default_nettype wire

// File: rtl/ci_latency_counter.sv
`default_nettype none
// ============================================================================
//  Module      : ci_latency_counter
//  Description : Saturating up-counter with synchronous clear and a
//                compare-to-limit flag. Measures FP unit latency and
//                doubles as the timeout timer.
//  Revision    : 1.0 - initial release
// ============================================================================
module ci_latency_counter
    import fp_ci_pkg::*;
#(
    parameter int                 WIDTH = DEFAULT_COUNTER_WIDTH,
    parameter logic [WIDTH-1:0]   LIMIT = {WIDTH{1'b1}}
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_clear,
    input  logic             i_inc,
    output logic [WIDTH-1:0] o_count,
    output logic             o_at_limit
);

    localparam logic [WIDTH-1:0] c_ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0] r_count;

    // Count up while enabled, stick at all-ones instead of wrapping.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_inc && (r_count != {WIDTH{1'b1}})) begin
            r_count <= r_count + c_ONE;
        end
    end

    assign o_count    = r_count;
    assign o_at_limit = (r_count == LIMIT);

endmodule
`default_nettype wire

// File: rtl/fp_ci_initiator.sv
`default_nettype none
// ============================================================================
//  Module      : fp_ci_initiator
//  Description : Initiator side of the multi-cycle FP custom-instruction
//                handshake. Takes one operand pair at a time, issues it as a
//                single clk_en pulse, waits for done, and returns the result
//                plus the measured latency on a valid/ready stream.
//                Optional feature macro: FP_CI_INITIATOR_TIMEOUT_EN
//                (abort with ci_aclr and out_err after TIMEOUT_CYCLES).
//  Revision    : 1.0 - initial release
// ============================================================================
module fp_ci_initiator
    import fp_ci_pkg::*;
#(
    parameter int DATA_WIDTH     = DEFAULT_DATA_WIDTH,
    parameter int COUNTER_WIDTH  = DEFAULT_COUNTER_WIDTH,
    parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [DATA_WIDTH-1:0]    in_a,
    input  logic [DATA_WIDTH-1:0]    in_b,
    output logic                     ci_clk_en,
    output logic                     ci_aclr,
    output logic [DATA_WIDTH-1:0]    ci_dataa,
    output logic [DATA_WIDTH-1:0]    ci_datab,
    input  logic [DATA_WIDTH-1:0]    ci_result,
    input  logic                     ci_done,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [DATA_WIDTH-1:0]    out_result,
    output logic [COUNTER_WIDTH-1:0] out_latency,
    output logic                     out_err
);

`ifdef FP_CI_INITIATOR_TIMEOUT_EN
    localparam logic c_TIMEOUT_EN = 1'b1;
`else
    localparam logic c_TIMEOUT_EN = 1'b0;
`endif

    localparam logic [COUNTER_WIDTH-1:0] c_TIMEOUT_LIMIT = COUNTER_WIDTH'(TIMEOUT_CYCLES - 1);
    localparam logic [COUNTER_WIDTH-1:0] c_TIMEOUT_LAT   = COUNTER_WIDTH'(TIMEOUT_CYCLES);
    localparam logic [COUNTER_WIDTH-1:0] c_ONE           = {{(COUNTER_WIDTH-1){1'b0}}, 1'b1};

    logic [STATE_W-1:0]       r_state;
    logic [STATE_W-1:0]       w_state_next;
    logic [DATA_WIDTH-1:0]    r_dataa;
    logic [DATA_WIDTH-1:0]    r_datab;
    logic [DATA_WIDTH-1:0]    r_result;
    logic [COUNTER_WIDTH-1:0] r_latency;
    logic [COUNTER_WIDTH-1:0] w_count;
    logic [COUNTER_WIDTH-1:0] w_lat_next;
    logic                     w_at_limit;
    logic                     w_accept;
    logic                     w_done_hit;
    logic                     w_timeout_hit;
    logic                     w_in_ready;
    logic                     w_clk_en;
    logic                     w_aclr;
    logic                     w_out_valid;

    // A done in the same cycle as the timeout wins; done outside WAIT is ignored.
    assign w_accept      = (r_state == S_IDLE) && in_valid;
    assign w_done_hit    = (r_state == S_WAIT) && ci_done;
    assign w_timeout_hit = (r_state == S_WAIT) && !ci_done && w_at_limit && c_TIMEOUT_EN;

    // Latency reported includes the done cycle itself, saturating at all-ones.
    assign w_lat_next = (w_count == {COUNTER_WIDTH{1'b1}}) ? w_count : (w_count + c_ONE);

    ci_latency_counter #(
        .WIDTH (COUNTER_WIDTH),
        .LIMIT (c_TIMEOUT_LIMIT)
    ) u_counter (
        .clk        (clk),
        .rst        (rst),
        .i_clear    (r_state == S_ISSUE),
        .i_inc      (r_state == S_WAIT),
        .o_count    (w_count),
        .o_at_limit (w_at_limit)
    );

    // State register; reset lands in FLUSH so an interrupted unit gets cleared.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_FLUSH;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state decode: strictly one operation in flight.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_FLUSH: w_state_next = S_IDLE;
            S_IDLE:  if (in_valid) w_state_next = S_ISSUE;
            S_ISSUE: w_state_next = S_WAIT;
            S_WAIT:  if (w_done_hit || w_timeout_hit) w_state_next = S_RESP;
            S_RESP:  if (out_ready) w_state_next = S_IDLE;
            default: w_state_next = S_FLUSH;
        endcase
    end

    // Output decode: handshake strobes depend on state only (aclr also on timeout).
    always_comb begin
        w_in_ready  = 1'b0;
        w_clk_en    = 1'b0;
        w_aclr      = 1'b0;
        w_out_valid = 1'b0;
        case (r_state)
            S_FLUSH: w_aclr      = 1'b1;
            S_IDLE:  w_in_ready  = 1'b1;
            S_ISSUE: w_clk_en    = 1'b1;
            S_WAIT:  w_aclr      = w_timeout_hit;
            S_RESP:  w_out_valid = 1'b1;
            default: w_aclr      = 1'b1;
        endcase
    end

    // Operand capture on accept and result/latency capture on completion.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_dataa   <= '0;
            r_datab   <= '0;
            r_result  <= '0;
            r_latency <= '0;
        end else begin
            if (w_accept) begin
                r_dataa <= in_a;
                r_datab <= in_b;
            end
            if (w_done_hit) begin
                r_result  <= ci_result;
                r_latency <= w_lat_next;
            end else if (w_timeout_hit) begin
                r_result  <= '0;
                r_latency <= c_TIMEOUT_LAT;
            end
        end
    end

`ifdef FP_CI_INITIATOR_TIMEOUT_EN
    logic r_err;

    // Error flag marks a result produced by abort rather than by the unit.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_err <= 1'b0;
        end else if (w_done_hit) begin
            r_err <= 1'b0;
        end else if (w_timeout_hit) begin
            r_err <= 1'b1;
        end
    end

    assign out_err = r_err;
`else
    assign out_err = 1'b0;
`endif

    assign in_ready    = w_in_ready;
    assign ci_clk_en   = w_clk_en;
    assign ci_aclr     = w_aclr;
    assign ci_dataa    = r_dataa;
    assign ci_datab    = r_datab;
    assign out_valid   = w_out_valid;
    assign out_result  = r_result;
    assign out_latency = r_latency;

endmodule
`default_nettype wire

// File: doc/fp_ci_initiator.md
Name: fp_ci_initiator

Overview:
- Master (initiator) side of the multi-cycle floating-point custom-instruction handshake: `clk_en`, `dataa`, `datab`, `result`, `done`, `aclr`.
- Accepts operand pairs from an upstream valid/ready stream and issues each to one attached multi-cycle FP unit (e.g. a mul-add unit) as a single-cycle `clk_en` pulse.
- Waits for the unit's `done` pulse, captures `result` and the measured latency, and presents them on a downstream valid/ready stream.
- Sits between the CORDIC iteration controller and the FP arithmetic units.

Parameters:
- DATA_WIDTH, 32, operand/result width.
- COUNTER_WIDTH, 10, width of the latency/timeout counter.
- TIMEOUT_CYCLES, 64, cycles waited for `done` before abort (used only with the optional feature); must be < 2^COUNTER_WIDTH.

Ports:
- clk  in  1  clock, all logic on rising edge.
- rst  in  1  asynchronous, active-low reset.
- in_valid  in  1  operand pair valid.
- in_ready  out  1  initiator can accept an operand pair.
- in_a  in  DATA_WIDTH  operand A.
- in_b  in  DATA_WIDTH  operand B.
- ci_clk_en  out  1  one-cycle issue pulse to the FP unit.
- ci_aclr  out  1  clear to the FP unit (flush/abort).
- ci_dataa  out  DATA_WIDTH  operand A to the FP unit, registered.
- ci_datab  out  DATA_WIDTH  operand B to the FP unit, registered.
- ci_result  in  DATA_WIDTH  FP unit result, valid when ci_done=1.
- ci_done  in  1  FP unit completion pulse.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts the result.
- out_result  out  DATA_WIDTH  captured result.
- out_latency  out  COUNTER_WIDTH  cycles from the ci_clk_en cycle to the ci_done cycle.
- out_err  out  1  result aborted by timeout.

Behaviour:
- Reset (rst=0, asynchronous): state=FLUSH; ci_aclr=1; all other outputs 0 (in_ready, ci_clk_en, ci_dataa, ci_datab, out_valid, out_result, out_latency, out_err); counter=0.
- States and transitions:
  - FLUSH: ci_aclr=1; next edge → IDLE with ci_aclr=0. This guarantees an FP unit interrupted mid-operation by our reset is cleared. in_ready=0.
  - IDLE: in_ready=1. On in_valid&in_ready: register in_a/in_b into ci_dataa/ci_datab → ISSUE.
  - ISSUE: ci_clk_en=1 for exactly this one cycle; counter←0 → WAIT.
  - WAIT: ci_clk_en=0; ci_dataa/ci_datab held stable; counter increments each cycle, saturating at all-ones. On ci_done=1:
    - out_result←ci_result; out_latency←counter+1 (saturating); out_err←0; out_valid←1 → RESP.
  - RESP: out_valid, out_result, out_latency and out_err held stable until out_ready=1. On out_ready=1 → IDLE with out_valid←0. The next operand is accepted no earlier than the cycle after the handshake (no bypass).
- in_ready is a registered/decoded state output only: 1 exactly in IDLE, never combinationally dependent on out_ready.
- Throughput: one operation in flight. Minimum accept-to-out_valid latency is 3 cycles with an FP unit of latency 1.
- ci_done asserted outside WAIT (spurious) is ignored; no state or output change.
- ci_done in the same cycle the timeout expires: ci_done wins, normal result.
- out_valid must never drop without out_ready.
- rst asserted mid-operation: immediate return to reset values, then FLUSH; any in-flight result is discarded.

Optional Feature:
- Macro: FP_CI_INITIATOR_TIMEOUT_EN.
- Defined: in WAIT, when counter reaches TIMEOUT_CYCLES-1 without ci_done:
  - ci_aclr=1 for one cycle;
  - out_result←0, out_err←1, out_latency←TIMEOUT_CYCLES, out_valid←1 → RESP.
- Not defined: WAIT lasts indefinitely; out_err tied 0; ci_aclr is asserted only in FLUSH.

Decomposition:
- Package fp_ci_pkg: state encoding (FLUSH, IDLE, ISSUE, WAIT, RESP), DATA_WIDTH/COUNTER_WIDTH defaults, default TIMEOUT_CYCLES.
- One sub-module: ci_latency_counter, a saturating up-counter with synchronous clear and a compare-to-limit flag. The same counter serves the latency measurement and the timeout.

Test Plan:
- Reset release → ci_aclr=1 for exactly one cycle, in_ready=1 on the following cycle, all other outputs 0.
- Model mul-add unit, latency 14. in_a=0x40000000, in_b=0x40400000 → single ci_clk_en pulse; out_result=0x41100000, out_latency=14, out_err=0.
- Same transfer with out_ready held 0 for 20 cycles → out_valid and out_result stable throughout; in_ready=0; second in_valid not accepted until the cycle after the handshake.
- ci_done pulsed during IDLE and during RESP → no state or output change; ci_done on the same cycle the timeout expires → normal result, out_err=0.
- Macro defined, TIMEOUT_CYCLES=64, unit never responds → ci_aclr pulse 64 cycles after ci_clk_en; out_valid=1, out_err=1, out_result=0, out_latency=64. Macro undefined → still waiting at cycle 1000.
- rst pulsed low during WAIT → outputs return to reset values immediately; FLUSH cycle on release; a late ci_done from the old operation is ignored; next operation completes correctly.
